// File: rtl/nib_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: slice width, FSM
// state encoding and small helper functions.
package nib_serial_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Slice counter width: clog2 of the slice count, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // One-bit full adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/nib_serial_sub_sub4.sv
// Combinational 4-bit ripple-borrow slice: d = a - b - borrow_in, built as
// a + ~b + ~borrow_in with full-adder cells; borrow_out is the inverted carry.
module nib_serial_sub_sub4
  import nib_serial_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               bin_i,
  output logic [SLICE_W-1:0] d_o,
  output logic               bout_o
);

  logic [SLICE_W:0] carry_s;

  // Ripple the inverted-borrow carry through the slice.
  always_comb begin
    carry_s    = '0;
    d_o        = '0;
    carry_s[0] = ~bin_i;
    for (int i = 0; i < SLICE_W; i++) begin
      {carry_s[i+1], d_o[i]} = full_add(a_i[i], ~b_i[i], carry_s[i]);
    end
    bout_o = ~carry_s[SLICE_W];
  end

endmodule

// File: rtl/nib_serial_sub.sv
// Nibble-serial subtractor: D = A - B - Bin, one 4-bit slice per clock,
// least-significant slice first, with a start/busy/done handshake.
module nib_serial_sub
  import nib_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_Bin,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_D,
  output logic             out_Bout,
  output logic             out_ovf
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e state_q, state_d;

  logic [CW-1:0]          cnt_q;
  logic [WIDTH-1:0]       a_q, b_q, res_q;
  logic                   borrow_q;
  logic [WIDTH-1:0]       d_q;
  logic                   bout_q, ovf_q, done_q, busy_q;

  logic                   accept_s, run_s, last_s;
  logic [SLICE_W-1:0]     slice_d_s;
  logic                   slice_bout_s;
  logic [WIDTH+SLICE_W-1:0] res_cat_s;
  logic [WIDTH-1:0]       res_shift_s;
  logic                   ovf_s;

  nib_serial_sub_sub4 u_sub4 (
    .a_i   (a_q[SLICE_W-1:0]),
    .b_i   (b_q[SLICE_W-1:0]),
    .bin_i (borrow_q),
    .d_o   (slice_d_s),
    .bout_o(slice_bout_s)
  );

  // New slice enters at the top; after N shifts slice 0 sits at the bottom.
  assign res_cat_s   = {slice_d_s, res_q};
  assign res_shift_s = res_cat_s[WIDTH+SLICE_W-1:SLICE_W];
  // Operand registers hold the top slice in their low nibble on the last step.
  assign ovf_s = (a_q[SLICE_W-1] != b_q[SLICE_W-1]) && (slice_d_s[SLICE_W-1] != a_q[SLICE_W-1]);

  // FSM state register.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_start ? RUN : IDLE;
      RUN:     state_d = last_s ? DONE : RUN;
      DONE:    state_d = in_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM control decode: accept a request, step a slice, detect the last slice.
  always_comb begin
    accept_s = 1'b0;
    run_s    = 1'b0;
    last_s   = 1'b0;
    case (state_q)
      IDLE:    accept_s = in_start;
      DONE:    accept_s = in_start;
      RUN: begin
        run_s  = 1'b1;
        last_s = (cnt_q == LAST_CNT);
      end
      default: accept_s = 1'b0;
    endcase
  end

  // Operand capture, per-slice shifting, borrow chaining and slice counting.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept_s) begin
      a_q      <= in_A;
      b_q      <= in_B;
      res_q    <= '0;
      borrow_q <= in_Bin;
      cnt_q    <= '0;
    end else if (run_s) begin
      a_q      <= a_q >> SLICE_W;
      b_q      <= b_q >> SLICE_W;
      res_q    <= res_shift_s;
      borrow_q <= slice_bout_s;
      if (!last_s) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= cnt_q;
      end
    end else begin
      a_q      <= a_q;
      b_q      <= b_q;
      res_q    <= res_q;
      borrow_q <= borrow_q;
      cnt_q    <= cnt_q;
    end
  end

  // Registered handshake flags and result registers loaded on completion.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= last_s;
      if (last_s) begin
        d_q    <= res_shift_s;
        bout_q <= slice_bout_s;
        ovf_q  <= ovf_s;
      end else begin
        d_q    <= d_q;
        bout_q <= bout_q;
        ovf_q  <= ovf_q;
      end
    end
  end

  assign out_busy = busy_q;
  assign out_done = done_q;
  assign out_D    = d_q;
  assign out_Bout = bout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_nib_serial_sub.sv
// Self-checking bench for nib_serial_sub (WIDTH = 16): directed cases with
// literal expectations plus randomized traffic against a behavioural model.
module tb_nib_serial_sub;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             in_clk = 1'b0;
  logic             in_rst = 1'b1;
  logic             in_start = 1'b0;
  logic [WIDTH-1:0] in_A = '0;
  logic [WIDTH-1:0] in_B = '0;
  logic             in_Bin = 1'b0;
  logic             out_busy, out_done, out_Bout, out_ovf;
  logic [WIDTH-1:0] out_D;

  int checks = 0;
  int errors = 0;

  // Behavioural model: operation in flight counts down remaining edges.
  int               m_rem = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_D = '0;
  logic             m_bout = 1'b0;
  logic             m_ovf = 1'b0;
  logic [WIDTH-1:0] p_D;
  logic             p_bout, p_ovf;

  nib_serial_sub #(.WIDTH(WIDTH)) dut (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_start(in_start),
    .in_A    (in_A),
    .in_B    (in_B),
    .in_Bin  (in_Bin),
    .out_busy(out_busy),
    .out_done(out_done),
    .out_D   (out_D),
    .out_Bout(out_Bout),
    .out_ovf (out_ovf)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, then predict the next cycle.
  initial begin
    forever begin
      @(negedge in_clk);
      if (in_rst) begin
        m_rem = 0; m_done = 1'b0; m_D = '0; m_bout = 1'b0; m_ovf = 1'b0;
      end
      chk("model_busy", {31'd0, out_busy}, {31'd0, (m_rem > 0)});
      chk("model_done", {31'd0, out_done}, {31'd0, m_done});
      chk("model_D",    {16'd0, out_D},    {16'd0, m_D});
      chk("model_Bout", {31'd0, out_Bout}, {31'd0, m_bout});
      chk("model_ovf",  {31'd0, out_ovf},  {31'd0, m_ovf});
      if (!in_rst) begin
        if (m_rem > 0) begin
          m_rem--;
          m_done = (m_rem == 0);
          if (m_rem == 0) begin
            m_D = p_D; m_bout = p_bout; m_ovf = p_ovf;
          end
        end else begin
          m_done = 1'b0;
          if (in_start) begin
            m_rem  = N;
            p_D    = WIDTH'(int'(in_A) - int'(in_B) - int'(in_Bin));
            p_bout = (int'(in_A) < int'(in_B) + int'(in_Bin));
            p_ovf  = (in_A[WIDTH-1] != in_B[WIDTH-1]) && (p_D[WIDTH-1] != in_A[WIDTH-1]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Single operation with literal expectations on result, latency and busy length.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic eo, input string nm);
    int edges = 0;
    int busy_cnt = 0;
    bit seen = 0;
    in_A = a; in_B = b; in_Bin = bin; in_start = 1'b1;
    tick();
    in_start = 1'b0; in_A = 16'($urandom); in_B = 16'($urandom); in_Bin = 1'($urandom);
    if (out_busy) busy_cnt++;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      edges++;
      if (out_busy) busy_cnt++;
      if (out_done) seen = 1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 20 edges", nm);
    end
    chk({nm, "_latency"}, edges, 32'd4);
    chk({nm, "_busy"}, busy_cnt, 32'd4);
    chk({nm, "_D"}, {16'd0, out_D}, {16'd0, ed});
    chk({nm, "_Bout"}, {31'd0, out_Bout}, {31'd0, eb});
    chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    tick();
  endtask

  initial begin
    int dcount;
    int gap;
    bit seen;

    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_done", {31'd0, out_done}, 32'd0);
    chk("rst_D", {16'd0, out_D}, 32'd0);
    chk("rst_Bout", {31'd0, out_Bout}, 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    in_rst = 1'b0;
    tick();

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "t1");
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "t2");
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "t3");
    run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, "t4");

    // Start during RUN must be ignored.
    in_A = 16'h00FF; in_B = 16'h000F; in_Bin = 1'b0; in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    in_A = 16'hFFFF; in_B = 16'hFFFF; in_start = 1'b1;
    tick();
    in_start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_done) begin
        dcount++;
        chk("ign_D", {16'd0, out_D}, 32'h0000_00F0);
      end
      tick();
    end
    chk("ign_done_count", dcount, 32'd1);

    // Reset mid-RUN: outputs clear at once, no done, clean restart.
    in_A = 16'h4321; in_B = 16'h1111; in_Bin = 1'b0; in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    tick();
    in_rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, out_busy}, 32'd0);
    chk("mid_rst_D", {16'd0, out_D}, 32'd0);
    chk("mid_rst_done", {31'd0, out_done}, 32'd0);
    tick();
    in_rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_done) dcount++;
      tick();
    end
    chk("rst_no_done", dcount, 32'd0);
    run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, "post_rst");

    // Back-to-back with start held high.
    in_A = 16'h0010; in_B = 16'h0001; in_Bin = 1'b0; in_start = 1'b1;
    tick();
    in_A = 16'h0003; in_B = 16'h0004;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_done) seen = 1; else tick();
    end
    if (!seen) begin errors++; $display("FAIL b2b_first_timeout: got no done expected done"); end
    chk("b2b_D1", {16'd0, out_D}, 32'h0000_000F);
    chk("b2b_B1", {31'd0, out_Bout}, 32'd0);
    gap = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      gap++;
      if (out_done) seen = 1;
    end
    in_start = 1'b0;
    chk("b2b_spacing", gap, 32'd5);
    chk("b2b_D2", {16'd0, out_D}, 32'h0000_FFFF);
    chk("b2b_B2", {31'd0, out_Bout}, 32'd1);
    repeat (3) tick();

    // Randomized traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 600; i++) begin
      in_start = ($urandom_range(0, 2) == 0);
      in_A = 16'($urandom);
      in_B = ($urandom_range(0, 7) == 0) ? in_A : 16'($urandom);
      in_Bin = 1'($urandom);
      in_rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_rst = 1'b0;
    in_start = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
